// File: rtl/pc_stack_unit_if.sv
// Instruction-sequencer bus: per-cycle control into the PC/stack unit and its status back out.
// Latency: none (wires only).
// Backpressure: none; the strobe is the only flow control, and the sequencer always accepts it.
interface pc_stack_unit_if #(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 8
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic             advance;
    logic [2:0]       op;
    logic [PC_W-1:0]  target;
    logic             clr_flags;
    logic [PC_W-1:0]  pc;
    logic [LVL_W-1:0] stack_level;
    logic             stack_full;
    logic             stack_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output advance, op, target, clr_flags,
        input  pc, stack_level, stack_full, stack_empty, overflow, underflow
    );

    modport slave (
        input  advance, op, target, clr_flags,
        output pc, stack_level, stack_full, stack_empty, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with circular call/return stack, goto/skip modes and sticky stack fault flags.
// Latency: one cycle; the new pc is visible after the edge on which advance is high. pc is registered only.
// Backpressure: none; each advance strobe is consumed. Optional macro STACK_TRAP_EN redirects stack faults to TRAP_VEC.
module pc_stack_unit #(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_VEC   = 0,
    parameter int TRAP_VEC    = 4
) (
    input  logic             clk,
    input  logic             reset,
    pc_stack_unit_if.slave   bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_GOTO   = 3'b001;
    localparam logic [2:0] OP_CALL   = 3'b010;
    localparam logic [2:0] OP_RETURN = 3'b011;
    localparam logic [2:0] OP_SKIP   = 3'b100;

    localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0]  TRAP_PC  = PC_W'(TRAP_VEC);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(STACK_DEPTH - 1);

`ifdef STACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic [PTR_W-1:0] wr_ptr, ptr_d, ptr_inc, ptr_dec;
    logic [LVL_W-1:0] level, level_d;
    logic             overflow_q, underflow_q;
    logic             push, ovf_set, unf_set;
    logic             is_full, is_empty;

    assign is_full  = (level == FULL_LVL);
    assign is_empty = (level == '0);
    assign pc_inc   = pc_q + PC_W'(1);
    assign ptr_inc  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    assign ptr_dec  = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PTR_W'(1);

    // Next pc / pointer / level and fault events for the current strobe.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = wr_ptr;
        level_d = level;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.advance) begin
            case (bus.op)
                OP_INC:  pc_d = pc_inc;
                OP_GOTO: pc_d = bus.target;
                OP_CALL: begin
                    // A full stack still pushes, overwriting the oldest entry.
                    push  = 1'b1;
                    ptr_d = ptr_inc;
                    pc_d  = bus.target;
                    if (is_full) begin
                        ovf_set = 1'b1;
                        if (TRAP_EN) pc_d = TRAP_PC;
                    end else begin
                        level_d = level + LVL_W'(1);
                    end
                end
                OP_RETURN: begin
                    if (is_empty) begin
                        unf_set = 1'b1;
                        pc_d    = TRAP_EN ? TRAP_PC : pc_inc;
                    end else begin
                        ptr_d   = ptr_dec;
                        pc_d    = stack_mem[ptr_dec];
                        level_d = level - LVL_W'(1);
                    end
                end
                OP_SKIP: pc_d = pc_q + PC_W'(2);
                default: pc_d = pc_q;
            endcase
        end
    end

    // Architectural state; the sticky flags let a same-edge fault win over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            wr_ptr      <= '0;
            level       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr      <= ptr_d;
            level       <= level_d;
            overflow_q  <= ovf_set | (overflow_q & ~bus.clr_flags);
            underflow_q <= unf_set | (underflow_q & ~bus.clr_flags);
        end
    end

    // Return-address storage: one write per cycle, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push && reset) stack_mem[wr_ptr] <= pc_inc;
    end

    assign bus.pc          = pc_q;
    assign bus.stack_level = level;
    assign bus.stack_full  = is_full;
    assign bus.stack_empty = is_empty;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: sequencing, call/return stack, faults, reset.
// Latency: checks sampled 1 time unit after the strobed edge.
// Backpressure: not applicable.
module tb_pc_stack_unit;
    localparam int PC_W = 13;
    localparam int DEPTH = 8;
    localparam logic [2:0] OP_INC = 3'b000, OP_GOTO = 3'b001, OP_CALL = 3'b010,
                           OP_RET = 3'b011, OP_SKIP = 3'b100, OP_HOLD = 3'b101;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    pc_stack_unit_if #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) bus ();

    pc_stack_unit #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [2:0] o, input logic [PC_W-1:0] t, input logic clr);
        @(negedge clk);
        bus.advance   = 1'b1;
        bus.op        = o;
        bus.target    = t;
        bus.clr_flags = clr;
        @(posedge clk);
        #1;
        bus.advance   = 1'b0;
        bus.clr_flags = 1'b0;
        bus.op        = OP_HOLD;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.advance = 1'b0;
            bus.op      = OP_GOTO;
            bus.target  = 13'h0AA;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.advance = 1'b0; bus.op = OP_HOLD; bus.target = '0; bus.clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.pc !== 13'h0000) begin n_fails++; $display("FAIL reset_pc: got %h want 0000", bus.pc); end
        n_checks++; if (bus.stack_level !== 4'd0) begin n_fails++; $display("FAIL reset_level: got %0d want 0", bus.stack_level); end
        n_checks++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin n_fails++; $display("FAIL reset_status: empty %b full %b want 1 0", bus.stack_empty, bus.stack_full); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fails++; $display("FAIL reset_flags: ovf %b unf %b want 0 0", bus.overflow, bus.underflow); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 5; i++) begin
            strobe(OP_INC, 13'h1234, 1'b0);
            n_checks++; if (bus.pc !== PC_W'(i)) begin n_fails++; $display("FAIL inc_pc[%0d]: got %h want %h", i, bus.pc, PC_W'(i)); end
            idle(3);
            n_checks++; if (bus.pc !== PC_W'(i)) begin n_fails++; $display("FAIL inc_hold[%0d]: got %h want %h", i, bus.pc, PC_W'(i)); end
        end
    endtask

    task automatic test_call_return();
        strobe(OP_GOTO, 13'h010, 1'b0);
        n_checks++; if (bus.pc !== 13'h010) begin n_fails++; $display("FAIL goto_pc: got %h want 0010", bus.pc); end
        strobe(OP_CALL, 13'h100, 1'b0);
        n_checks++; if (bus.pc !== 13'h100 || bus.stack_level !== 4'd1) begin n_fails++; $display("FAIL call_pc_level: got %h/%0d want 0100/1", bus.pc, bus.stack_level); end
        strobe(OP_RET, 13'h1FF, 1'b0);
        n_checks++; if (bus.pc !== 13'h011 || bus.stack_level !== 4'd0 || bus.stack_empty !== 1'b1) begin n_fails++; $display("FAIL ret_pc_level: got %h/%0d/%b want 0011/0/1", bus.pc, bus.stack_level, bus.stack_empty); end
    endtask

    task automatic test_nested();
        logic [PC_W-1:0] exp_pc;
        for (int k = 0; k < 9; k++) begin
            strobe(OP_CALL, PC_W'(13'h200 + k), 1'b0);
            exp_pc = PC_W'(13'h200 + k);
`ifdef STACK_TRAP_EN
            if (k == 8) exp_pc = 13'h004;
`endif
            n_checks++; if (bus.pc !== exp_pc) begin n_fails++; $display("FAIL nest_call_pc[%0d]: got %h want %h", k, bus.pc, exp_pc); end
            n_checks++; if (bus.stack_level !== ((k < 8) ? 4'(k + 1) : 4'd8)) begin n_fails++; $display("FAIL nest_level[%0d]: got %0d", k, bus.stack_level); end
            n_checks++; if (bus.overflow !== (k == 8)) begin n_fails++; $display("FAIL nest_ovf[%0d]: got %b want %b", k, bus.overflow, (k == 8)); end
        end
        n_checks++; if (bus.stack_full !== 1'b1) begin n_fails++; $display("FAIL nest_full: got %b want 1", bus.stack_full); end
        for (int j = 0; j < 8; j++) begin
            strobe(OP_RET, 13'h000, 1'b0);
            n_checks++; if (bus.pc !== PC_W'(13'h208 - j)) begin n_fails++; $display("FAIL nest_ret_pc[%0d]: got %h want %h", j, bus.pc, PC_W'(13'h208 - j)); end
            n_checks++; if (bus.stack_level !== 4'(7 - j)) begin n_fails++; $display("FAIL nest_ret_level[%0d]: got %0d want %0d", j, bus.stack_level, 7 - j); end
        end
        n_checks++; if (bus.stack_empty !== 1'b1 || bus.overflow !== 1'b1) begin n_fails++; $display("FAIL nest_end: empty %b ovf %b want 1 1", bus.stack_empty, bus.overflow); end
        // clear with advance low: flag drops, pc untouched
        @(negedge clk); bus.clr_flags = 1'b1;
        @(posedge clk); #1; bus.clr_flags = 1'b0;
        n_checks++; if (bus.overflow !== 1'b0 || bus.pc !== 13'h201) begin n_fails++; $display("FAIL clr_ovf: ovf %b pc %h want 0 0201", bus.overflow, bus.pc); end
    endtask

    task automatic test_underflow();
        logic [PC_W-1:0] exp_pc;
        strobe(OP_GOTO, 13'h050, 1'b0);
        strobe(OP_RET, 13'h000, 1'b0);
`ifdef STACK_TRAP_EN
        exp_pc = 13'h004;
`else
        exp_pc = 13'h051;
`endif
        n_checks++; if (bus.pc !== exp_pc) begin n_fails++; $display("FAIL unf_pc: got %h want %h", bus.pc, exp_pc); end
        n_checks++; if (bus.underflow !== 1'b1 || bus.stack_level !== 4'd0) begin n_fails++; $display("FAIL unf_flag: unf %b level %0d want 1 0", bus.underflow, bus.stack_level); end
        @(negedge clk); bus.clr_flags = 1'b1; bus.op = OP_RET;
        @(posedge clk); #1; bus.clr_flags = 1'b0;
        n_checks++; if (bus.underflow !== 1'b0 || bus.pc !== exp_pc) begin n_fails++; $display("FAIL clr_unf: unf %b pc %h want 0 %h", bus.underflow, bus.pc, exp_pc); end
        strobe(OP_RET, 13'h000, 1'b1);
        n_checks++; if (bus.underflow !== 1'b1) begin n_fails++; $display("FAIL clr_vs_fault: unf %b want 1", bus.underflow); end
    endtask

    task automatic test_skip_goto_hold();
        strobe(OP_GOTO, 13'h1FFF, 1'b0);
        strobe(OP_SKIP, 13'h0000, 1'b0);
        n_checks++; if (bus.pc !== 13'h0001) begin n_fails++; $display("FAIL skip_wrap: got %h want 0001", bus.pc); end
        strobe(OP_SKIP, 13'h0000, 1'b0);
        n_checks++; if (bus.pc !== 13'h0003) begin n_fails++; $display("FAIL skip_pc: got %h want 0003", bus.pc); end
        @(negedge clk); bus.op = OP_GOTO; bus.target = 13'h0AA; bus.advance = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.pc !== 13'h0003) begin n_fails++; $display("FAIL goto_no_adv: got %h want 0003", bus.pc); end
        strobe(OP_HOLD, 13'h0AA, 1'b0);
        n_checks++; if (bus.pc !== 13'h0003) begin n_fails++; $display("FAIL hold_101: got %h want 0003", bus.pc); end
        strobe(3'b111, 13'h0AA, 1'b0);
        n_checks++; if (bus.pc !== 13'h0003) begin n_fails++; $display("FAIL hold_111: got %h want 0003", bus.pc); end
    endtask

    task automatic test_reset_mid_call();
        strobe(OP_GOTO, 13'h030, 1'b0);
        strobe(OP_CALL, 13'h300, 1'b0);
        n_checks++; if (bus.pc !== 13'h300 || bus.stack_level !== 4'd1) begin n_fails++; $display("FAIL pre_reset: got %h/%0d want 0300/1", bus.pc, bus.stack_level); end
        @(negedge clk);
        bus.advance = 1'b1; bus.op = OP_CALL; bus.target = 13'h123;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 13'h000 || bus.stack_level !== 4'd0) begin n_fails++; $display("FAIL async_reset: got %h/%0d want 0000/0", bus.pc, bus.stack_level); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fails++; $display("FAIL async_reset_flag: unf %b want 0", bus.underflow); end
        @(posedge clk); #1;
        n_checks++; if (bus.pc !== 13'h000 || bus.stack_level !== 4'd0) begin n_fails++; $display("FAIL reset_edge: got %h/%0d want 0000/0", bus.pc, bus.stack_level); end
        @(negedge clk);
        bus.advance = 1'b0;
        reset = 1'b1;
        strobe(OP_INC, 13'h000, 1'b0);
        n_checks++; if (bus.pc !== 13'h001 || bus.stack_empty !== 1'b1) begin n_fails++; $display("FAIL post_reset: got %h/%b want 0001/1", bus.pc, bus.stack_empty); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_inc();
        test_call_return();
        test_nested();
        test_underflow();
        test_skip_goto_hold();
        test_reset_mid_call();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised successor to the fixed 13-bit program counter: instruction-address sequencer for the PIC-style core.
- Adds a hardware call/return stack, goto/skip modes and stack status flags.
- Updates once per instruction cycle, when the phase generator asserts `advance` (normally the Q4/saveFiles strobe).
- Its `pc` output drives the instruction memory address.

Parameters:
- PC_W, 13, program counter width in bits.
- STACK_DEPTH, 8, number of return-address entries (≥2).
- RESET_VEC, 0, PC value after reset.
- TRAP_VEC, 4, PC loaded on a stack fault; used only when STACK_TRAP_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- advance  input  1  instruction-cycle strobe; PC/stack change only when 1.
- op  input  3  000 INC, 001 GOTO, 010 CALL, 011 RETURN, 100 SKIP, others HOLD.
- target  input  PC_W  destination for GOTO/CALL.
- clr_flags  input  1  clears sticky fault flags.
- pc  output  PC_W  current instruction address.
- stack_level  output  $clog2(STACK_DEPTH+1)  valid entries, 0..STACK_DEPTH.
- stack_full  output  1  stack_level == STACK_DEPTH.
- stack_empty  output  1  stack_level == 0.
- overflow  output  1  sticky: CALL while full.
- underflow  output  1  sticky: RETURN while empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, stack_level=0, write pointer=0, overflow=0, underflow=0.
  - Stack RAM contents are don't-care.
  - Reset is honoured mid-operation, including an edge where advance=1; no partial update survives.
- advance=0: pc, stack and level hold; op and target are ignored.
- advance=1: state updates on that rising edge; the new pc is visible after the edge (1-cycle latency).
- All PC arithmetic is modulo 2^PC_W.
  - INC: pc+1.
  - SKIP: pc+2, e.g. 0x1FFF→0x0001 when PC_W=13.
- GOTO: pc=target; stack unchanged.
- CALL:
  - Push pc+1 (wrapped) at the write pointer, advance the pointer (mod STACK_DEPTH), pc=target.
  - Not full: level+1.
  - Full: circular overwrite of the oldest entry, level stays STACK_DEPTH, overflow←1.
- RETURN:
  - Not empty: pointer-1 (mod STACK_DEPTH), pc=entry at the new pointer, level-1.
  - Empty: pc=pc+1, pointer and level unchanged, underflow←1.
- HOLD (101,110,111): no change.
- clr_flags=1 clears overflow and underflow on the edge.
  - If a fault occurs on the same edge, the set wins: the flag reads 1.
  - clr_flags acts regardless of advance.
- stack_full and stack_empty are combinational from stack_level.
- Stack storage is a register array, single write per cycle.
- No combinational path from op or target to pc.

Optional Feature:
- Macro: STACK_TRAP_EN.
- Defined: a CALL while full or a RETURN while empty loads pc=TRAP_VEC instead of target or pc+1.
  - Flags still set.
  - The overflow CALL still performs the circular push.
  - The underflow RETURN leaves the stack unchanged.
- Undefined: behaviour exactly as in Behaviour; TRAP_VEC unused.

Test Plan:
- Reset 0→1 with RESET_VEC=0, then 5 INC strobes with advance pulsed every 4th clk → pc 0,1,2,3,4,5; pc holds between strobes.
- pc=0x010, CALL target=0x100 → pc=0x100, level=1; then RETURN → pc=0x011, level=0, stack_empty=1.
- 9 nested CALLs with targets 0x200..0x208, DEPTH=8 → level saturates at 8, overflow=1 on the 9th; then 8 RETURNs return the 8 newest addresses (0x201..0x208 chain, newest first).
- RETURN with level=0 at pc=0x050 → pc=0x051, underflow=1. With STACK_TRAP_EN → pc=0x004.
- SKIP at pc=0x1FFF → pc=0x0001. GOTO 0x0AA with advance=0 → pc unchanged.
- reset asserted between clk edges during a CALL cycle → pc=RESET_VEC and level=0 immediately; clr_flags with a simultaneous fault → flag stays 1.
